// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative MULT/DIV sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFixup,
    StDone
  } state_e;

  localparam logic OpMul = 1'b0;
  localparam logic OpDiv = 1'b1;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultCntW  = $clog2(DefaultWidth);

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the decode stage and the MULT/DIV sequencer.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op_div;
  logic             is_signed;
  logic             flush;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op_div, is_signed, flush, a, b,
    input  busy, stall, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op_div, is_signed, flush, a, b,
    output busy, stall, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               op_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_next;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: acc = {remainder, dividend bits being shifted out / quotient shifted in}
    shifted  = acc[2*WIDTH-1:WIDTH-1];
    q_bit    = 1'b0;
    rem_next = shifted[WIDTH-1:0];
    acc_next = {sum, acc[WIDTH-1:1]};
    if (op_div) begin
      q_bit    = (shifted >= {1'b0, operand});
      rem_next = q_bit ? WIDTH'(shifted - {1'b0, operand}) : shifted[WIDTH-1:0];
      // Quotient bit is merged into the LSB by the sequencer.
      acc_next = {rem_next, acc[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/DIV sequencer: stalls the pipe for WIDTH+1 cycles, then writes HI/LO.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
  logic [WIDTH-1:0]   opd_q, opd_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               op_div_q, op_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic               dbz_q, dbz_d;
  logic               sign_a, sign_b, q_bit, busy;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_div   (op_div_q),
    .acc      (acc_q),
    .operand  (opd_q),
    .acc_next (step_acc),
    .q_bit    (q_bit)
  );

  assign sign_a = bus.is_signed & bus.a[WIDTH-1];
  assign sign_b = bus.is_signed & bus.b[WIDTH-1];
  assign abs_a  = sign_a ? -bus.a : bus.a;
  assign abs_b  = sign_b ? -bus.b : bus.b;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    op_div_d = op_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    prod     = neg_lo_q ? -acc_q : acc_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush) begin
          op_div_d = bus.op_div;
          if (bus.op_div == OpDiv && bus.b == '0) begin
            hi_d    = bus.a;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            acc_d    = (bus.op_div == OpDiv) ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            opd_d    = (bus.op_div == OpDiv) ? abs_b : abs_a;
            neg_lo_d = sign_a ^ sign_b;
            neg_hi_d = sign_a;
            cnt_d    = CntW'(WIDTH - 1);
            state_d  = StIter;
          end
        end
      end
      StIter: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, q_bit};
          if (cnt_q == '0) state_d = StFixup;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      StFixup: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          if (op_div_q) begin
            lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end else begin
            {hi_d, lo_d} = prod;
          end
          dbz_d   = 1'b0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
      op_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      op_div_q <= op_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy            = (state_q == StIter) || (state_q == StFixup);
  assign bus.busy        = busy;
  assign bus.stall       = (bus.start && state_q == StIdle) || busy;
  assign bus.done        = (state_q == StDone);
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vector bench for muldiv_sequencer: result table plus flush/reset/ignored-start sequences.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  typedef struct {
    logic        op_div;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[13];

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int cyc;
    bit stall_ok;
    bus.op_div    = v.op_div;
    bus.is_signed = v.is_signed;
    bus.a         = v.a;
    bus.b         = v.b;
    bus.start     = 1'b1;
    #1;
    check($sformatf("v%0d stall_c0", idx), bus.stall, 1);
    tick();
    bus.start = 1'b0;
    cyc       = 1;
    stall_ok  = 1'b1;
    while (!bus.done && cyc < 100) begin
      if (!bus.stall || !bus.busy) stall_ok = 1'b0;
      tick();
      cyc++;
    end
    check($sformatf("v%0d latency", idx), cyc, v.lat);
    check($sformatf("v%0d hi", idx), bus.hi, v.hi);
    check($sformatf("v%0d lo", idx), bus.lo, v.lo);
    check($sformatf("v%0d dbz", idx), bus.div_by_zero, v.dbz);
    check($sformatf("v%0d busy_at_done", idx), bus.busy, 0);
    check($sformatf("v%0d stall_while_busy", idx), stall_ok, 1);
    tick();
    check($sformatf("v%0d done_pulse", idx), bus.done, 0);
    check($sformatf("v%0d dbz_held", idx), bus.div_by_zero, v.dbz);
  endtask

  task automatic watch_no_done(input string name, input logic [31:0] hi, input logic [31:0] lo);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen = 1'b1;
      tick();
    end
    check({name, " no_done"}, seen, 0);
    check({name, " hi_kept"}, bus.hi, hi);
    check({name, " lo_kept"}, bus.lo, lo);
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{OpMul, 1'b0, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE, 1'b0, 34};
    vecs[1]  = '{OpMul, 1'b1, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
    vecs[2]  = '{OpDiv, 1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[3]  = '{OpDiv, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34};
    vecs[4]  = '{OpDiv, 1'b0, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1, 1};
    vecs[5]  = '{OpDiv, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34};
    vecs[6]  = '{OpMul, 1'b0, 32'h10000, 32'h10000, 32'h1, 32'h0, 1'b0, 34};
    vecs[7]  = '{OpDiv, 1'b1, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, 34};
    vecs[8]  = '{OpDiv, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF, 1'b0, 34};
    vecs[9]  = '{OpMul, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 34};
    vecs[10] = '{OpMul, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, 34};
    vecs[11] = '{OpDiv, 1'b1, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1};
    vecs[12] = '{OpDiv, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, 34};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    bus.op_div    = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset dbz", bus.div_by_zero, 0);
    check("reset hi", bus.hi, 0);
    check("reset lo", bus.lo, 0);
    check("reset stall", bus.stall, 0);

    foreach (vecs[i]) run_op(vecs[i], i);

    // Flush at cycle 10 of a multiply: back to IDLE, previous results kept.
    bus.op_div = OpMul; bus.is_signed = 1'b0; bus.a = 32'd5; bus.b = 32'd6; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush busy_c11", bus.busy, 0);
    check("flush stall_c11", bus.stall, 0);
    watch_no_done("flush", 32'h80000000, 32'h0);

    // Start at cycle 5 and during DONE must be ignored.
    bus.op_div = OpMul; bus.a = 32'd3; bus.b = 32'd4; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.op_div = OpDiv; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 6;
    while (!bus.done && cyc < 100) begin
      tick();
      cyc++;
    end
    check("ignored latency", cyc, 34);
    check("ignored hi", bus.hi, 32'h0);
    check("ignored lo", bus.lo, 32'd12);
    bus.op_div = OpMul; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_in_done busy", bus.busy, 0);
    watch_no_done("ignored", 32'h0, 32'd12);

    // Flush together with start in IDLE drops the request.
    bus.start = 1'b1; bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start busy", bus.busy, 0);
    watch_no_done("flush_start", 32'h0, 32'd12);

    // Reset mid-operation after a divide-by-zero has left div_by_zero set.
    run_op(vecs[4], 4);
    bus.op_div = OpDiv; bus.is_signed = 1'b1; bus.a = 32'hFFFFFFF9; bus.b = 32'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst = 1'b1; bus.start = 1'b1; bus.flush = 1'b1;
    tick();
    rst = 1'b0; bus.start = 1'b0; bus.flush = 1'b0;
    check("midrst busy", bus.busy, 0);
    check("midrst done", bus.done, 0);
    check("midrst dbz", bus.div_by_zero, 0);
    check("midrst hi", bus.hi, 0);
    check("midrst lo", bus.lo, 0);
    tick();
    check("midrst idle", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
